sap_control_sequencer: RTL and testbench
========================================

Name: sap_control_sequencer

Overview:
- Control unit for the 8-bit shared-bus datapath. It is the initiator for every bus transfer.
- Each cycle it drives the load, output-enable and sub strobes that the accumulator, adder/subtractor, B register, PC, MAR, RAM, IR and output register respond to.
- It runs a fetch/decode/execute step counter and decodes a 4-bit opcode from the IR.
- It uses the CF/ZF flags for conditional jumps.

Parameters:
- OP_W, 4, opcode width; only 4 is supported.
- LAST_STEP, 4, highest step index (T0..T4).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  step enable; when low, the step counter and halt state hold.
- opcode  in  4  IR upper nibble; valid from T2 onward.
- cf  in  1  carry flag from the adder/subtractor.
- zf  in  1  zero flag from the adder/subtractor.
- pc_out, pc_inc, pc_load  out  1 each  program counter: drive bus / increment / load from bus.
- mar_load  out  1  memory address register loads from bus.
- ram_out, ram_in  out  1 each  RAM: drive bus / write from bus.
- ir_load, ir_out  out  1 each  IR: load / drive operand nibble (zero-extended) onto bus.
- a_load, a_out  out  1 each  accumulator: load / enable_output.
- b_load  out  1  B register loads from bus.
- alu_out  out  1  adder enable_output.
- sub  out  1  adder subtract select.
- out_load  out  1  output register loads from bus.
- flags_load  out  1  CF/ZF register update.
- halt  out  1  processor halted.
- step  out  3  current T-state, for debug.
- instr_done  out  1  high during the last step of each instruction.

Behaviour:
- State:
  - step counter, 0..LAST_STEP;
  - halted latch.
- Reset (rst=1 at posedge): step=0, halted=0.
- While rst=1, all strobe outputs are forced to 0.
- Outputs are combinational from step, opcode, cf, zf and halted. They are 0 in any step not listed below.
- Fetch (every instruction):
  - T0: pc_out, mar_load.
  - T1: ram_out, ir_load, pc_inc.
- Execute, by opcode:
  - NOP 0x0: T2 empty; last step T2.
  - LDA 0x1: T2 ir_out, mar_load; T3 ram_out, a_load; last T3.
  - ADD 0x2: T2 ir_out, mar_load; T3 ram_out, b_load; T4 alu_out, a_load, flags_load; last T4.
  - SUB 0x3: as ADD, with sub=1 in T4 only; last T4.
  - STA 0x4: T2 ir_out, mar_load; T3 a_out, ram_in; last T3.
  - LDI 0x5: T2 ir_out, a_load; last T2.
  - JMP 0x6: T2 ir_out, pc_load; last T2.
  - JC 0x7: T2 ir_out, pc_load only if cf=1, else empty; last T2.
  - JZ 0x8: as JC but uses zf.
  - OUT 0xE: T2 a_out, out_load; last T2.
  - HLT 0xF: T2 sets halted at the posedge.
  - 0x9–0xD: treated as NOP.
- Step advance (posedge with run=1, halted=0):
  - step=0 if the current step is the instruction's last step;
  - otherwise step+1.
  - instr_done equals "last step" for the current step, gated by run.
- run=0: step holds. Outputs still reflect the current step, so strobes repeat each cycle; the datapath is idempotent for these transfers.
- Halt:
  - halted=1 holds step at 2.
  - All strobes are 0, halt=1, instr_done=0.
  - Only rst clears halted.
- Bus rule: at most one of pc_out, ram_out, ir_out, a_out, alu_out is high in any cycle. This is an invariant.
- Reset mid-instruction: the next cycle is T0 with all strobes 0 during reset. No partial load is issued in the reset cycle.
- The step counter never exceeds LAST_STEP. An illegal step value (from an upset) forces step=0 on the next edge.

Test Plan:
- Reset, then run=1, opcode=0x1 (LDA):
  - steps 0,1,2,3,0 on successive edges;
  - T3 shows ram_out=1, a_load=1, instr_done=1, all other strobes 0.
- opcode=0x3 (SUB):
  - T4 has alu_out=1, a_load=1, flags_load=1, sub=1;
  - sub=0 in T0–T3;
  - instr_done only at T4.
- JC with cf=0: T2 all strobes 0, instr_done=1, next step=0.
- JC with cf=1: T2 ir_out=1, pc_load=1.
- opcode=0xF (HLT):
  - after the T2 edge, halt=1 and step stays 2 for 10 cycles with all strobes 0;
  - assert rst for one cycle: step=0, halt=0.
- run=0 at step 3 for 4 cycles: step stays 3 and outputs are stable; run=1 resumes to step 4 (ADD).
- Random opcodes and flags for 10k cycles: the one-bus-driver invariant is never violated and step never exceeds 4.
- rst asserted at T3 of ADD: all strobes are 0 during the reset cycle and step=0 after it.

Source files
------------

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer
// Step-counter control unit for the 8-bit shared-bus datapath. It walks
// T0..T4 for each instruction, decodes the IR opcode and drives every
// load / output-enable strobe. The CF and ZF flags qualify the conditional
// jumps, and a halt latch stops the machine until reset.
module sap_control_sequencer #(
  parameter int OP_W      = 4,
  parameter int LAST_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [OP_W-1:0] opcode,
  input  logic            cf,
  input  logic            zf,
  output logic            pc_out,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            mar_load,
  output logic            ram_out,
  output logic            ram_in,
  output logic            ir_load,
  output logic            ir_out,
  output logic            a_load,
  output logic            a_out,
  output logic            b_load,
  output logic            alu_out,
  output logic            sub,
  output logic            out_load,
  output logic            flags_load,
  output logic            halt,
  output logic [2:0]      step,
  output logic            instr_done
);

  localparam logic [2:0] STEP_MAX = 3'(LAST_STEP);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] step_reg, step_next;
  logic       halted_reg, halted_next;
  logic [2:0] last_step;
  logic       at_last;
  logic       step_illegal;
  logic       active;

  // Last T-state of the current instruction; every instruction ends at T2 or later.
  always_comb begin
    last_step = 3'd2;
    case (opcode)
      OP_LDA, OP_STA: last_step = 3'd3;
      OP_ADD, OP_SUB: last_step = 3'd4;
      default:        last_step = 3'd2;
    endcase
    // ">=" keeps the counter bounded even if the opcode changes mid-instruction.
    at_last      = (step_reg >= last_step);
    step_illegal = (step_reg > STEP_MAX);
    active       = !rst && !halted_reg && !step_illegal;
  end

  // Next step / halt latch: wrap at the last step, freeze at T2 once halted.
  always_comb begin
    step_next   = step_reg;
    halted_next = halted_reg;
    if (step_illegal) begin
      step_next = 3'd0;
    end else if (run && !halted_reg) begin
      if (at_last) begin
        if (opcode == OP_HLT) begin
          halted_next = 1'b1;
          step_next   = step_reg;
        end else begin
          step_next = 3'd0;
        end
      end else begin
        step_next = step_reg + 3'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_reg   <= 3'd0;
      halted_reg <= 1'b0;
    end else begin
      step_reg   <= step_next;
      halted_reg <= halted_next;
    end
  end

  // Strobe decode from step, opcode and flags; everything is quiet in reset or halt.
  always_comb begin
    pc_out     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    ram_out    = 1'b0;
    ram_in     = 1'b0;
    ir_load    = 1'b0;
    ir_out     = 1'b0;
    a_load     = 1'b0;
    a_out      = 1'b0;
    b_load     = 1'b0;
    alu_out    = 1'b0;
    sub        = 1'b0;
    out_load   = 1'b0;
    flags_load = 1'b0;
    halt       = halted_reg;
    step       = step_reg;
    instr_done = active && run && at_last;
    if (active) begin
      case (step_reg)
        3'd0: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        3'd1: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
        3'd2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out   = 1'b1;
              mar_load = 1'b1;
            end
            OP_LDI: begin
              ir_out = 1'b1;
              a_load = 1'b1;
            end
            OP_JMP: begin
              ir_out  = 1'b1;
              pc_load = 1'b1;
            end
            OP_JC: begin
              ir_out  = cf;
              pc_load = cf;
            end
            OP_JZ: begin
              ir_out  = zf;
              pc_load = zf;
            end
            OP_OUT: begin
              a_out    = 1'b1;
              out_load = 1'b1;
            end
            default: ;
          endcase
        end
        3'd3: begin
          case (opcode)
            OP_LDA: begin
              ram_out = 1'b1;
              a_load  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out = 1'b1;
              b_load  = 1'b1;
            end
            OP_STA: begin
              a_out  = 1'b1;
              ram_in = 1'b1;
            end
            default: ;
          endcase
        end
        3'd4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out    = 1'b1;
            a_load     = 1'b1;
            flags_load = 1'b1;
            sub        = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: a microcode-table model of each
// instruction, checked against the DUT on every cycle, plus directed cases.
module tb_sap_control_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, run, cf, zf;
  logic [3:0] opcode;
  logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_out, sub, out_load, flags_load, halt, instr_done;
  logic [2:0] step;

  sap_control_sequencer #(.OP_W(4), .LAST_STEP(4)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .cf(cf), .zf(zf),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ram_in(ram_in), .ir_load(ir_load), .ir_out(ir_out),
    .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
    .sub(sub), .out_load(out_load), .flags_load(flags_load), .halt(halt),
    .step(step), .instr_done(instr_done)
  );

  // Strobe bit positions inside a 15-bit mask.
  localparam logic [14:0] M_PCO  = 15'h4000;
  localparam logic [14:0] M_PCI  = 15'h2000;
  localparam logic [14:0] M_PCL  = 15'h1000;
  localparam logic [14:0] M_MARL = 15'h0800;
  localparam logic [14:0] M_RAMO = 15'h0400;
  localparam logic [14:0] M_RAMI = 15'h0200;
  localparam logic [14:0] M_IRL  = 15'h0100;
  localparam logic [14:0] M_IRO  = 15'h0080;
  localparam logic [14:0] M_AL   = 15'h0040;
  localparam logic [14:0] M_AO   = 15'h0020;
  localparam logic [14:0] M_BL   = 15'h0010;
  localparam logic [14:0] M_ALUO = 15'h0008;
  localparam logic [14:0] M_SUB  = 15'h0004;
  localparam logic [14:0] M_OUTL = 15'h0002;
  localparam logic [14:0] M_FL   = 15'h0001;

  int errors = 0;
  int checks = 0;

  logic [14:0] micro [16][5];
  int          len_tab [16];
  int          m_step;
  bit          m_halted;
  bit          chk_en;

  logic [14:0] s_mask;
  int          s_step;
  int          s_done;
  int          s_halt;

  function automatic logic [14:0] act_mask();
    return {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out,
            a_load, a_out, b_load, alu_out, sub, out_load, flags_load};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance model at the edge.
  task automatic cycle(input bit r, input bit ru, input logic [3:0] op, input bit c, input bit z);
    logic [14:0] e;
    int          ed;
    int          nb;
    rst = r; run = ru; opcode = op; cf = c; zf = z;
    #1;
    s_mask = act_mask();
    s_step = int'(step);
    s_done = int'(instr_done);
    s_halt = int'(halt);
    nb = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
    if (chk_en) begin
      e = '0;
      if (!r && !m_halted) begin
        e = micro[op][m_step];
        if (op == 4'h7 && m_step == 2 && !c) e = '0;
        if (op == 4'h8 && m_step == 2 && !z) e = '0;
      end
      ed = (!r && !m_halted && ru && m_step == len_tab[op]) ? 1 : 0;
      chk("strobes", int'(s_mask), int'(e));
      chk("step", s_step, m_step);
      chk("halt", s_halt, int'(m_halted));
      chk("instr_done", s_done, ed);
      chk("one_bus_driver", int'(nb <= 1), 1);
      chk("step_range", int'(s_step <= 4), 1);
    end
    @(posedge clk);
    if (r) begin
      m_step = 0;
      m_halted = 1'b0;
    end else if (ru && !m_halted) begin
      if (m_step == len_tab[op]) begin
        if (op == 4'hF) m_halted = 1'b1;
        else m_step = 0;
      end else begin
        m_step++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int          seq [4];
    logic [3:0]  cur_op;
    // Microcode table: fetch is common, execute rows per opcode.
    for (int o = 0; o < 16; o++) begin
      len_tab[o] = 2;
      for (int t = 0; t < 5; t++) micro[o][t] = '0;
      micro[o][0] = M_PCO | M_MARL;
      micro[o][1] = M_RAMO | M_IRL | M_PCI;
    end
    micro[1][2] = M_IRO | M_MARL; micro[1][3] = M_RAMO | M_AL;  len_tab[1] = 3;
    micro[2][2] = M_IRO | M_MARL; micro[2][3] = M_RAMO | M_BL;
    micro[2][4] = M_ALUO | M_AL | M_FL;                         len_tab[2] = 4;
    micro[3][2] = M_IRO | M_MARL; micro[3][3] = M_RAMO | M_BL;
    micro[3][4] = M_ALUO | M_AL | M_FL | M_SUB;                 len_tab[3] = 4;
    micro[4][2] = M_IRO | M_MARL; micro[4][3] = M_AO | M_RAMI;  len_tab[4] = 3;
    micro[5][2] = M_IRO | M_AL;
    micro[6][2] = M_IRO | M_PCL;
    micro[7][2] = M_IRO | M_PCL;
    micro[8][2] = M_IRO | M_PCL;
    micro[14][2] = M_AO | M_OUTL;

    chk_en = 1'b0;
    rst = 1'b1; run = 1'b0; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
    m_step = 0; m_halted = 1'b0;
    @(negedge clk);
    cycle(1, 0, 4'h0, 0, 0);
    chk_en = 1'b1;

    // Reset state
    cycle(1, 1, 4'h1, 0, 0);
    chk("reset_strobes", int'(s_mask), 0);
    cycle(0, 0, 4'h1, 0, 0);
    chk("reset_step", s_step, 0);
    chk("reset_halt", s_halt, 0);

    // LDA: steps 0,1,2,3 then wrap
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 4'h1, 0, 0);
      seq[i] = s_step;
      if (i == 3) begin
        chk("lda_t3_strobes", int'(s_mask), int'(M_RAMO | M_AL));
        chk("lda_t3_done", s_done, 1);
      end
    end
    for (int i = 0; i < 4; i++) chk("lda_step_seq", seq[i], i);

    // SUB: sub only at T4, done only at T4
    for (int t = 0; t < 5; t++) begin
      cycle(0, 1, 4'h3, 0, 0);
      if (t == 0) chk("lda_wrap_step", s_step, 0);
      chk("sub_step", s_step, t);
      chk("sub_flag", int'(s_mask[2]), int'(t == 4));
      chk("sub_done", s_done, int'(t == 4));
      if (t == 4) chk("sub_t4_strobes", int'(s_mask), int'(M_ALUO | M_AL | M_FL | M_SUB));
    end

    // JC not taken, then JC taken
    cycle(0, 1, 4'h7, 0, 0);
    cycle(0, 1, 4'h7, 0, 0);
    cycle(0, 1, 4'h7, 0, 0);
    chk("jc0_t2_strobes", int'(s_mask), 0);
    chk("jc0_t2_done", s_done, 1);
    cycle(0, 1, 4'h7, 1, 0);
    chk("jc0_wrap_step", s_step, 0);
    cycle(0, 1, 4'h7, 1, 0);
    cycle(0, 1, 4'h7, 1, 0);
    chk("jc1_t2_strobes", int'(s_mask), int'(M_IRO | M_PCL));

    // ADD with run held low at T3
    for (int i = 0; i < 3; i++) cycle(0, 1, 4'h2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 4'h2, 0, 0);
      chk("stall_step", s_step, 3);
      chk("stall_strobes", int'(s_mask), int'(M_RAMO | M_BL));
    end
    cycle(0, 1, 4'h2, 0, 0);
    cycle(0, 1, 4'h2, 0, 0);
    chk("resume_step", s_step, 4);

    // Reset at T3 of ADD
    for (int i = 0; i < 3; i++) cycle(0, 1, 4'h2, 0, 0);
    cycle(1, 1, 4'h2, 0, 0);
    chk("midreset_strobes", int'(s_mask), 0);
    cycle(0, 0, 4'h2, 0, 0);
    chk("midreset_step", s_step, 0);

    // HLT: freeze at T2 until reset
    for (int i = 0; i < 3; i++) cycle(0, 1, 4'hF, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 4'hF, 1, 1);
      chk("hlt_halt", s_halt, 1);
      chk("hlt_step", s_step, 2);
      chk("hlt_strobes", int'(s_mask), 0);
    end
    cycle(1, 1, 4'hF, 0, 0);
    cycle(0, 0, 4'h0, 0, 0);
    chk("hlt_reset_step", s_step, 0);
    chk("hlt_reset_halt", s_halt, 0);

    // Random instruction stream; opcode only changes on instruction boundaries.
    cur_op = 4'h0;
    for (int n = 0; n < 10000; n++) begin
      if (m_step == 0 && !m_halted) cur_op = 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) != 0), cur_op,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
